// File: rtl/des_pkg.sv
// Shared DES types, tables and permutation helpers for the iterative engine.
// Tables use the standard 1-based, MSB-first DES bit numbering.
package des_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} des_state_t;

  localparam logic MODE_DECRYPT = 1'b0;
  localparam logic MODE_ENCRYPT = 1'b1;
  localparam int   DES_ROUNDS   = 16;

  // Bit r set when key-schedule round r rotates by two instead of one.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29,  21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,  3,28,15,6,21,10,  23,19,12,4,26,8,
                                16,7,27,20,13,2,  41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int E_T [48] = '{32,1,2,3,4,5,     4,5,6,7,8,9,      8,9,10,11,12,13,
                              12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                              24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21, 29,12,28,17, 1,15,23,26, 5,18,31,10,
                              2,8,24,14,  32,27,3,9,   19,13,30,6, 22,11,4,25};

  // Each S-box is 64 nibbles, row-major, first entry in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic bit rpc_legal(input int rpc);
    return (rpc == 1) || (rpc == 2) || (rpc == 4) || (rpc == 8) || (rpc == 16);
  endfunction

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - IP_T[i])]};
    return y;
  endfunction

  function automatic logic [63:0] ip_inv_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(64 - IP_T[i])] = x[6'(63 - i)];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y = {y[54:0], x[6'(64 - PC1_T[i])]};
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y = {y[46:0], x[6'(56 - PC2_T[i])]};
    return y;
  endfunction

  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] x);
    logic [255:0] sh;
    logic [5:0]   a;
    a  = {x[5], x[0], x[4:1]};
    sh = SBOX[n] >> {6'd63 - a, 2'b00};
    return sh[3:0];
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, p;
    x = '0;
    for (int i = 0; i < 48; i++) x = {x[46:0], r[5'(32 - E_T[i])]};
    x = x ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = {s[27:0], sbox(3'(i), x[47:42])};
      x = x << 6;
    end
    p = '0;
    for (int i = 0; i < 32; i++) p = {p[30:0], s[5'(32 - P_T[i])]};
    return p;
  endfunction

endpackage

// File: rtl/des_primitives.sv
// DES building blocks: initial/final permutations, key PC-1 and one Feistel round
// with its key-schedule step.
module IP
  import des_pkg::*;
(
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);
  assign data_o = ip_perm(data_i);
endmodule

module IP_Inverse
  import des_pkg::*;
(
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);
  assign data_o = ip_inv_perm(data_i);
endmodule

module Permutation_1
  import des_pkg::*;
(
  input  logic [63:0] key_i,
  output logic [27:0] c_o,
  output logic [27:0] d_o
);
  assign {c_o, d_o} = pc1_perm(key_i);
endmodule

module DES_round
  import des_pkg::*;
(
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [27:0] c_i,
  input  logic [27:0] d_i,
  input  logic [3:0]  round_i,
  input  logic        mode_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o,
  output logic [27:0] c_o,
  output logic [27:0] d_o
);
  logic        two;
  logic [27:0] c_l, d_l, c_r, d_r;
  logic [47:0] subkey;

  assign two = SHIFT2[round_i];
  assign c_l = two ? {c_i[25:0], c_i[27:26]} : {c_i[26:0], c_i[27]};
  assign d_l = two ? {d_i[25:0], d_i[27:26]} : {d_i[26:0], d_i[27]};
  assign c_r = two ? {c_i[1:0], c_i[27:2]}   : {c_i[0], c_i[27:1]};
  assign d_r = two ? {d_i[1:0], d_i[27:2]}   : {d_i[0], d_i[27:1]};

  // Encrypt rotates left then derives K; decrypt derives K from the current
  // halves (K16 == PC2(C0,D0)) and then rotates right to walk the schedule back.
  assign subkey = (mode_i == MODE_ENCRYPT) ? pc2_perm({c_l, d_l}) : pc2_perm({c_i, d_i});
  assign c_o    = (mode_i == MODE_ENCRYPT) ? c_l : c_r;
  assign d_o    = (mode_i == MODE_ENCRYPT) ? d_l : d_r;
  assign l_o    = r_i;
  assign r_o    = l_i ^ f_func(r_i, subkey);
endmodule

// File: rtl/des_round_chain.sv
// Combinational chain of ROUNDS_PER_CYCLE DES rounds starting at round counter cnt_i.
module des_round_chain
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic [4:0]  cnt_i,
  input  logic        mode_i,
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [27:0] c_i,
  input  logic [27:0] d_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o,
  output logic [27:0] c_o,
  output logic [27:0] d_o
);
  logic [ROUNDS_PER_CYCLE:0][31:0] l_s, r_s;
  logic [ROUNDS_PER_CYCLE:0][27:0] c_s, d_s;

  assign l_s[0] = l_i;
  assign r_s[0] = r_i;
  assign c_s[0] = c_i;
  assign d_s[0] = d_i;

  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_stage
    logic [4:0] step;
    logic [3:0] idx;
    assign step = cnt_i + 5'(k);
    assign idx  = (mode_i == MODE_ENCRYPT) ? step[3:0] : 4'd15 - step[3:0];

    DES_round u_round (
      .l_i(l_s[k]), .r_i(r_s[k]), .c_i(c_s[k]), .d_i(d_s[k]),
      .round_i(idx), .mode_i(mode_i),
      .l_o(l_s[k+1]), .r_o(r_s[k+1]), .c_o(c_s[k+1]), .d_o(d_s[k+1])
    );
  end

  assign l_o = l_s[ROUNDS_PER_CYCLE];
  assign r_o = r_s[ROUNDS_PER_CYCLE];
  assign c_o = c_s[ROUNDS_PER_CYCLE];
  assign d_o = d_s[ROUNDS_PER_CYCLE];
endmodule

// File: rtl/des_iterative_engine.sv
// Iterative DES encrypt/decrypt engine: one block per transaction, ROUNDS_PER_CYCLE
// rounds per RUN cycle, valid/ready on both sides.
module des_iterative_engine
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int TAG_W            = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [63:0]      in_data,
  input  logic [63:0]      in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  if (!rpc_legal(ROUNDS_PER_CYCLE)) begin : g_bad_rpc
    $error("des_iterative_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

  des_state_t       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      l_q, l_d, r_q, r_d;
  logic [27:0]      key_c_q, key_c_d, key_d_q, key_d_d;
  logic             mode_q, mode_d;
  logic [TAG_W-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
  logic [63:0]      out_data_q, out_data_d;

  logic [63:0] ip_data, fin_data;
  logic [27:0] pc1_c, pc1_d, ch_c, ch_d;
  logic [31:0] ch_l, ch_r;

  IP            u_ip  (.data_i(in_data), .data_o(ip_data));
  Permutation_1 u_pc1 (.key_i(in_key), .c_o(pc1_c), .d_o(pc1_d));

  des_round_chain #(.ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)) u_chain (
    .cnt_i(cnt_q), .mode_i(mode_q),
    .l_i(l_q), .r_i(r_q), .c_i(key_c_q), .d_i(key_d_q),
    .l_o(ch_l), .r_o(ch_r), .c_o(ch_c), .d_o(ch_d)
  );

  // Final swap of the halves happens here, on the chain output of the last RUN cycle.
  IP_Inverse u_ipi (.data_i({ch_r, ch_l}), .data_o(fin_data));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    l_d        = l_q;
    r_d        = r_q;
    key_c_d    = key_c_q;
    key_d_d    = key_d_q;
    mode_d     = mode_q;
    tag_d      = tag_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        {l_d, r_d} = ip_data;
        key_c_d    = pc1_c;
        key_d_d    = pc1_d;
        mode_d     = in_mode;
        tag_d      = in_tag;
        cnt_d      = '0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        l_d     = ch_l;
        r_d     = ch_r;
        key_c_d = ch_c;
        key_d_d = ch_d;
        cnt_d   = cnt_q + STEP;
        if (cnt_d == 5'(DES_ROUNDS)) begin
          out_data_d = fin_data;
          out_tag_d  = tag_q;
          state_d    = S_DONE;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      l_q        <= '0;
      r_q        <= '0;
      key_c_q    <= '0;
      key_d_q    <= '0;
      mode_q     <= MODE_DECRYPT;
      tag_q      <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      l_q        <= l_d;
      r_q        <= r_d;
      key_c_q    <= key_c_d;
      key_d_q    <= key_d_d;
      mode_q     <= mode_d;
      tag_q      <= tag_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
endmodule
